// File: rtl/prirv32_pkg.sv
// Shared branch-predictor types: 2-bit counter encoding, FSM states, saturating update.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package prirv32_pkg;

  typedef logic [1:0] bht_ctr_t;

  // Lower values lean towards taken; the fetch unit predicts taken for 00 and 01.
  localparam bht_ctr_t STRONG_TOKEN   = 2'b00;
  localparam bht_ctr_t WEAK_TOKEN     = 2'b01;
  localparam bht_ctr_t WEAK_NOTOKEN   = 2'b10;
  localparam bht_ctr_t STRONG_NOTOKEN = 2'b11;

  typedef enum logic {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_e;

  // Taken moves towards STRONG_TOKEN, not-taken towards STRONG_NOTOKEN, both saturating.
  function automatic bht_ctr_t bht_next(input bht_ctr_t state, input logic taken);
    bht_ctr_t res;
    res = state;
    if (taken) begin
      if (state != STRONG_TOKEN) res = state - 2'd1;
    end else begin
      if (state != STRONG_NOTOKEN) res = state + 2'd1;
    end
    return res;
  endfunction

  function automatic logic bht_is_taken(input bht_ctr_t state);
    return (state == STRONG_TOKEN) || (state == WEAK_TOKEN);
  endfunction

endpackage

// File: rtl/prirv32_bht_if.sv
// Fetch lookup, execute write-back and perf-counter signals of the branch history table.
// Latency: lookup combinational; updates visible on lookup one cycle after capture.
// Backpressure: none; ready_o only marks that initialisation is done.
interface prirv32_bht_if;
  import prirv32_pkg::*;

  logic [31:0] lookup_pc_i;
  bht_ctr_t    lookup_counter_o;
  logic        lookup_taken_o;
  logic        ready_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_pred_i;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  // Pipeline side: drives PCs and resolved outcomes, consumes predictions and counts.
  modport master (
    output lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i,
    input  lookup_counter_o, lookup_taken_o, ready_o, branch_cnt_o, mispred_cnt_o
  );

  // Table side.
  modport slave (
    input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i,
    output lookup_counter_o, lookup_taken_o, ready_o, branch_cnt_o, mispred_cnt_o
  );

endinterface

// File: rtl/prirv32_bht_ram.sv
// ENTRIES x 2-bit counter storage, one asynchronous read port, one synchronous write port.
// Latency: read combinational; write lands on the rising edge.
// Backpressure: none.
module prirv32_bht_ram
  import prirv32_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic               clk_in,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  bht_ctr_t           wr_dat_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output bht_ctr_t           rd_dat_o
);

  // Contents are deliberately not reset; the parent's INIT sweep fills them.
  bht_ctr_t mem_q [ENTRIES];

  // Single write port.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/prirv32_bht.sv
// Branch history table: 2-bit saturating counters, INIT sweep, registered update with forwarding, perf counts.
// Latency: lookup combinational; an update captured at edge N is seen by lookups from cycle N+1 via bypass.
// Backpressure: none; updates arriving before ready_o are dropped and not counted.
module prirv32_bht
  import prirv32_pkg::*;
#(
  parameter int       ENTRIES    = 64,
  parameter bht_ctr_t INIT_STATE = WEAK_TOKEN
) (
  input logic          clk_in,
  input logic          rst_in,
  prirv32_bht_if.slave bus
);

  localparam int                 INDEX_W  = $clog2(ENTRIES);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

  bht_state_e         state_q, state_d;
  logic [INDEX_W-1:0] init_idx_q, init_idx_d;
  logic               ready_q, ready_d;
  logic               pend_vld_q, pend_vld_d;
  logic [INDEX_W-1:0] pend_idx_q, pend_idx_d;
  bht_ctr_t           pend_val_q, pend_val_d;
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  bht_ctr_t           wr_dat;
  bht_ctr_t           lk_rd_dat, up_rd_dat;
  bht_ctr_t           lk_ctr, up_cur, up_next;

  assign lk_idx = bus.lookup_pc_i[INDEX_W+1:2];
  assign up_idx = bus.upd_pc_i[INDEX_W+1:2];

  // PC bits outside the index field intentionally alias.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc_i[31:INDEX_W+2], bus.lookup_pc_i[1:0],
                            bus.upd_pc_i[31:INDEX_W+2], bus.upd_pc_i[1:0]};

  // Write mux: INIT sweep owns the port until RUN, then the pending update drains into it.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = init_idx_q;
    wr_dat = INIT_STATE;
    if (!rst_in) begin
      if (state_q == BHT_INIT) begin
        wr_en = 1'b1;
      end else if (pend_vld_q) begin
        wr_en  = 1'b1;
        wr_idx = pend_idx_q;
        wr_dat = pend_val_q;
      end
    end
  end

  // Storage is duplicated so the fetch lookup and the update read-modify-write
  // each get their own read port; both copies always receive the same writes.
  prirv32_bht_ram #(.ENTRIES(ENTRIES)) u_lk_ram (
    .clk_in   (clk_in),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_dat_i (wr_dat),
    .rd_idx_i (lk_idx),
    .rd_dat_o (lk_rd_dat)
  );

  prirv32_bht_ram #(.ENTRIES(ENTRIES)) u_up_ram (
    .clk_in   (clk_in),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_dat_i (wr_dat),
    .rd_idx_i (up_idx),
    .rd_dat_o (up_rd_dat)
  );

  // Lookup: constant during INIT, otherwise bypass the not-yet-written pending value.
  always_comb begin
    lk_ctr = lk_rd_dat;
    if (state_q == BHT_INIT) begin
      lk_ctr = INIT_STATE;
    end else if (pend_vld_q && (pend_idx_q == lk_idx)) begin
      lk_ctr = pend_val_q;
    end
  end

  assign bus.lookup_counter_o = lk_ctr;
  assign bus.lookup_taken_o   = bht_is_taken(lk_ctr);

  // Update source is forwarded from pending so back-to-back hits on one index accumulate.
  always_comb begin
    up_cur = up_rd_dat;
    if (pend_vld_q && (pend_idx_q == up_idx)) up_cur = pend_val_q;
    up_next = bht_next(up_cur, bus.upd_taken_i);
  end

  // Next-state: INIT sweep, then capture one update per cycle into the pending stage.
  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    pend_vld_d    = 1'b0;
    pend_idx_d    = pend_idx_q;
    pend_val_d    = pend_val_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    case (state_q)
      BHT_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = BHT_RUN;
      end
      default: begin
        if (bus.upd_valid_i) begin
          pend_vld_d   = 1'b1;
          pend_idx_d   = up_idx;
          pend_val_d   = up_next;
          branch_cnt_d = branch_cnt_q + 32'd1;
          if (bus.upd_taken_i != bus.upd_pred_i) mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
      end
    endcase
    ready_d = (state_d == BHT_RUN);
  end

  // State registers; reset restarts the sweep and drops any pending update.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= BHT_INIT;
      init_idx_q    <= '0;
      ready_q       <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_idx_q    <= '0;
      pend_val_q    <= INIT_STATE;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      ready_q       <= ready_d;
      pend_vld_q    <= pend_vld_d;
      pend_idx_q    <= pend_idx_d;
      pend_val_q    <= pend_val_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.ready_o       = ready_q;
  assign bus.branch_cnt_o  = branch_cnt_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;

endmodule
